// File: rtl/tensor_core_pkg.sv
// Shared types and constants for the tensor core operand/result register file.
// Address map: addr[5:4] selects the region, addr[3:0] is row*4+col.
package tensor_core_pkg;

    localparam int BUS_WIDTH       = 8;
    localparam int MATRIX_DIM      = 4;
    localparam int MATRIX_ELEMS    = MATRIX_DIM * MATRIX_DIM;
    localparam int HOST_ADDR_WIDTH = 6;

    localparam logic [1:0] REGION_MATRIX1 = 2'b00;
    localparam logic [1:0] REGION_MATRIX2 = 2'b01;
    localparam logic [1:0] REGION_RESULT  = 2'b10;
    localparam logic [1:0] REGION_ZERO    = 2'b11;

    typedef enum logic [1:0] {
        OP_MATMUL = 2'b00,
        OP_ADD    = 2'b01,
        OP_RELU   = 2'b10
    } tensor_op_e;

    typedef enum logic [1:0] {
        DEST_RESULT     = 2'd0,
        DEST_MATRIX1    = 2'd1,
        DEST_MATRIX2    = 2'd2,
        DEST_RESULT_ALT = 2'd3
    } tensor_dest_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_START   = 3'd2,
        ST_ACK     = 3'd3,
        ST_WAIT    = 3'd4,
        ST_CAPTURE = 3'd5
    } regfile_state_e;

    function automatic logic [1:0] addr_region(input logic [HOST_ADDR_WIDTH-1:0] addr);
        return addr[5:4];
    endfunction

endpackage

// File: rtl/tensor_core_register_file.sv
// Operand/result register file in front of small_tensor_core: host byte port,
// command handshake and the start/ack/wait/capture sequence around the core.
module tensor_core_register_file
    import tensor_core_pkg::*;
#(
    parameter int ADDR_WIDTH = HOST_ADDR_WIDTH
) (
    input  logic                        clock_in,
    input  logic                        reset_n_in,
    input  logic                        host_write_valid,
    output logic                        host_write_ready,
    input  logic [ADDR_WIDTH-1:0]       host_write_address,
    input  logic signed [BUS_WIDTH-1:0] host_write_data,
    input  logic [ADDR_WIDTH-1:0]       host_read_address,
    output logic signed [BUS_WIDTH-1:0] host_read_data,
    input  logic                        command_valid,
    output logic                        command_ready,
    input  logic [1:0]                  command_operation,
    input  logic [1:0]                  command_destination,
    output logic                        command_done,
    output logic                        busy,
    output logic signed [BUS_WIDTH-1:0] tensor_core_input1 [MATRIX_DIM][MATRIX_DIM],
    output logic signed [BUS_WIDTH-1:0] tensor_core_input2 [MATRIX_DIM][MATRIX_DIM],
    output logic                        tensor_core_register_file_write_enable,
    output logic                        should_start_tensor_core,
    output logic [1:0]                  operation_select,
    input  logic signed [BUS_WIDTH-1:0] tensor_core_output [MATRIX_DIM][MATRIX_DIM],
    input  logic                        is_done_with_calculation
);

    regfile_state_e state_r;
    regfile_state_e state_next_s;
    tensor_dest_e   dest_r;
    logic [1:0]     op_r;
    logic           idle_r;
    logic           write_enable_r;
    logic           start_r;
    logic           done_r;

    logic signed [BUS_WIDTH-1:0] matrix1_r [MATRIX_DIM][MATRIX_DIM];
    logic signed [BUS_WIDTH-1:0] matrix2_r [MATRIX_DIM][MATRIX_DIM];
    logic signed [BUS_WIDTH-1:0] result_r  [MATRIX_DIM][MATRIX_DIM];
    logic signed [BUS_WIDTH-1:0] read_data_r;
    logic signed [BUS_WIDTH-1:0] read_mux_s;

    logic       write_fire_s;
    logic       command_fire_s;
    logic       write_to_operand_s;
    logic [1:0] wr_region_s;
    logic [1:0] wr_row_s;
    logic [1:0] wr_col_s;
    logic [1:0] rd_region_s;
    logic [1:0] rd_row_s;
    logic [1:0] rd_col_s;

    // idle_r is low during reset, so neither handshake can fire until the first edge after release
    assign host_write_ready   = idle_r;
    assign command_ready      = idle_r && !host_write_valid;
    assign write_fire_s       = host_write_valid && host_write_ready;
    assign command_fire_s     = command_valid && command_ready;
    assign wr_region_s        = addr_region(host_write_address);
    assign wr_row_s           = host_write_address[3:2];
    assign wr_col_s           = host_write_address[1:0];
    assign rd_region_s        = addr_region(host_read_address);
    assign rd_row_s           = host_read_address[3:2];
    assign rd_col_s           = host_read_address[1:0];
    assign write_to_operand_s = (wr_region_s == REGION_MATRIX1) || (wr_region_s == REGION_MATRIX2);

    assign busy                                   = (state_r != ST_IDLE);
    assign command_done                           = done_r;
    assign should_start_tensor_core               = start_r;
    assign tensor_core_register_file_write_enable = write_enable_r;
    assign operation_select                       = op_r;
    assign host_read_data                         = read_data_r;
    assign tensor_core_input1                     = matrix1_r;
    assign tensor_core_input2                     = matrix2_r;

    // Next-state logic for the command sequencer
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (command_fire_s) state_next_s = ST_ARM;
                else                state_next_s = ST_IDLE;
            end
            ST_ARM: begin
                if (is_done_with_calculation) state_next_s = ST_START;
                else                          state_next_s = ST_ARM;
            end
            ST_START: begin
                state_next_s = ST_ACK;
            end
            ST_ACK: begin
                if (!is_done_with_calculation) state_next_s = ST_WAIT;
                else                           state_next_s = ST_ACK;
            end
            ST_WAIT: begin
                if (is_done_with_calculation) state_next_s = ST_CAPTURE;
                else                          state_next_s = ST_WAIT;
            end
            ST_CAPTURE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Sequencer state, latched command and registered strobes
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_r        <= ST_IDLE;
            dest_r         <= DEST_RESULT;
            op_r           <= 2'b00;
            idle_r         <= 1'b0;
            write_enable_r <= 1'b0;
            start_r        <= 1'b0;
            done_r         <= 1'b0;
        end else begin
            state_r        <= state_next_s;
            idle_r         <= (state_next_s == ST_IDLE);
            write_enable_r <= write_fire_s && write_to_operand_s;
            start_r        <= (state_next_s == ST_START);
            done_r         <= (state_r == ST_CAPTURE);
            if (command_fire_s) begin
                op_r   <= command_operation;
                dest_r <= tensor_dest_e'(command_destination);
            end
        end
    end

    // Matrix storage: host writes in IDLE, core capture in CAPTURE (never both in one cycle)
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            for (int i = 0; i < MATRIX_DIM; i++) begin
                for (int j = 0; j < MATRIX_DIM; j++) begin
                    matrix1_r[i][j] <= 8'sd0;
                    matrix2_r[i][j] <= 8'sd0;
                    result_r[i][j]  <= 8'sd0;
                end
            end
        end else begin
            if (write_fire_s) begin
                case (wr_region_s)
                    REGION_MATRIX1: matrix1_r[wr_row_s][wr_col_s] <= host_write_data;
                    REGION_MATRIX2: matrix2_r[wr_row_s][wr_col_s] <= host_write_data;
                    default: begin
                    end
                endcase
            end
            if (state_r == ST_CAPTURE) begin
                for (int i = 0; i < MATRIX_DIM; i++) begin
                    for (int j = 0; j < MATRIX_DIM; j++) begin
                        result_r[i][j] <= tensor_core_output[i][j];
                        if (dest_r == DEST_MATRIX1) matrix1_r[i][j] <= tensor_core_output[i][j];
                        if (dest_r == DEST_MATRIX2) matrix2_r[i][j] <= tensor_core_output[i][j];
                    end
                end
            end
        end
    end

    // Host read multiplexer; the top region always reads as zero
    always_comb begin
        read_mux_s = 8'sd0;
        case (rd_region_s)
            REGION_MATRIX1: read_mux_s = matrix1_r[rd_row_s][rd_col_s];
            REGION_MATRIX2: read_mux_s = matrix2_r[rd_row_s][rd_col_s];
            REGION_RESULT:  read_mux_s = result_r[rd_row_s][rd_col_s];
            REGION_ZERO:    read_mux_s = 8'sd0;
            default:        read_mux_s = 8'sd0;
        endcase
    end

    // Registered host read data, one cycle behind the sampled address
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            read_data_r <= 8'sd0;
        end else begin
            read_data_r <= read_mux_s;
        end
    end

endmodule

// File: tb/tb_tensor_core_register_file.sv
// Directed bench for tensor_core_register_file with a behavioural stand-in for
// small_tensor_core (done drops while it recomputes, then rises with the result).
module tb_tensor_core_register_file;
    import tensor_core_pkg::*;

    logic              clock_in = 1'b0;
    logic              reset_n_in;
    logic              host_write_valid;
    logic              host_write_ready;
    logic [5:0]        host_write_address;
    logic signed [7:0] host_write_data;
    logic [5:0]        host_read_address;
    logic signed [7:0] host_read_data;
    logic              command_valid;
    logic              command_ready;
    logic [1:0]        command_operation;
    logic [1:0]        command_destination;
    logic              command_done;
    logic              busy;
    logic signed [7:0] tc_in1 [4][4];
    logic signed [7:0] tc_in2 [4][4];
    logic              rf_we;
    logic              core_start;
    logic [1:0]        operation_select;
    logic signed [7:0] core_out [4][4] = '{default: 8'sd0};
    logic signed [7:0] calc [4][4];
    logic              core_done = 1'b1;

    int core_lat = 3;
    int core_cnt = 0;
    int core_acc;
    int done_pulses = 0;
    int we_pulses = 0;
    int n_checks = 0;
    int n_fail = 0;

    tensor_core_register_file #(.ADDR_WIDTH(6)) dut (
        .clock_in(clock_in),
        .reset_n_in(reset_n_in),
        .host_write_valid(host_write_valid),
        .host_write_ready(host_write_ready),
        .host_write_address(host_write_address),
        .host_write_data(host_write_data),
        .host_read_address(host_read_address),
        .host_read_data(host_read_data),
        .command_valid(command_valid),
        .command_ready(command_ready),
        .command_operation(command_operation),
        .command_destination(command_destination),
        .command_done(command_done),
        .busy(busy),
        .tensor_core_input1(tc_in1),
        .tensor_core_input2(tc_in2),
        .tensor_core_register_file_write_enable(rf_we),
        .should_start_tensor_core(core_start),
        .operation_select(operation_select),
        .tensor_core_output(core_out),
        .is_done_with_calculation(core_done)
    );

    always #5 clock_in = ~clock_in;

    // Reference arithmetic of the core: 8-bit truncating matmul / add, relu of operand 1
    always_comb begin
        core_acc = 0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                core_acc = 0;
                for (int k = 0; k < 4; k++) core_acc = core_acc + int'(tc_in1[i][k]) * int'(tc_in2[k][j]);
                case (operation_select)
                    2'b00:   calc[i][j] = core_acc[7:0];
                    2'b01:   calc[i][j] = tc_in1[i][j] + tc_in2[i][j];
                    default: calc[i][j] = (tc_in1[i][j] < 0) ? 8'sd0 : tc_in1[i][j];
                endcase
            end
        end
    end

    // Core timing: start or operand change drops done, result appears when done rises
    always @(posedge clock_in) begin
        if (core_start) begin
            core_done <= 1'b0;
            core_cnt  <= core_lat;
        end else if (rf_we) begin
            core_done <= 1'b0;
            core_cnt  <= 2;
        end else if (core_cnt > 0) begin
            core_cnt <= core_cnt - 1;
        end else if (!core_done) begin
            core_done <= 1'b1;
            core_out  <= calc;
        end
        if (command_done) done_pulses <= done_pulses + 1;
        if (rf_we) we_pulses <= we_pulses + 1;
    end

    task automatic check_eq(input string tag, input logic signed [31:0] actual, input logic signed [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock_in);
        #1;
    endtask

    task automatic host_write(input int addr, input int data);
        int n = 0;
        host_write_address = addr[5:0];
        host_write_data    = data[7:0];
        host_write_valid   = 1'b1;
        #1;
        while (!host_write_ready && n < 50) begin
            tick();
            n++;
        end
        if (!host_write_ready) check_eq("write_ready_timeout", host_write_ready, 1);
        tick();
        host_write_valid = 1'b0;
    endtask

    task automatic host_read(input int addr, output logic signed [7:0] d);
        host_read_address = addr[5:0];
        tick();
        d = host_read_data;
    endtask

    task automatic issue_cmd(input logic [1:0] op, input logic [1:0] dest);
        int n = 0;
        command_operation   = op;
        command_destination = dest;
        command_valid       = 1'b1;
        #1;
        while (!command_ready && n < 50) begin
            tick();
            n++;
        end
        check_eq("cmd_ready", command_ready, 1);
        tick();
        command_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (command_done !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        check_eq("done_seen", command_done, 1);
    endtask

    logic signed [7:0] d;
    int d0;
    int w0;

    initial begin
        reset_n_in          = 1'b0;
        host_write_valid    = 1'b0;
        host_write_address  = 6'd0;
        host_write_data     = 8'sd0;
        host_read_address   = 6'd0;
        command_valid       = 1'b0;
        command_operation   = 2'b00;
        command_destination = 2'b00;
        repeat (3) @(posedge clock_in);
        #1;
        check_eq("rst_write_ready", host_write_ready, 0);
        check_eq("rst_cmd_ready", command_ready, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_read_data", host_read_data, 0);
        check_eq("rst_done", command_done, 0);
        check_eq("rst_start", core_start, 0);
        check_eq("rst_we", rf_we, 0);
        check_eq("rst_opsel", operation_select, 0);
        check_eq("rst_in1", tc_in1[2][3], 0);
        reset_n_in = 1'b1;
        tick();
        check_eq("idle_write_ready", host_write_ready, 1);
        check_eq("idle_cmd_ready", command_ready, 1);

        // single element write and read-back
        w0 = we_pulses;
        host_write(5, 7);
        repeat (4) tick();
        check_eq("we_single", we_pulses - w0, 1);
        host_read(5, d);
        check_eq("read_addr5", d, 7);
        check_eq("in1_1_1", tc_in1[1][1], 7);
        host_write(40, 9);
        repeat (3) tick();
        check_eq("we_result_region", we_pulses - w0, 1);
        host_read(40, d);
        check_eq("read_dropped", d, 0);
        host_read(50, d);
        check_eq("read_zero_region", d, 0);

        // identity x (1..16)
        for (int i = 0; i < 16; i++) begin
            host_write(i, (i % 5 == 0) ? 1 : 0);
            host_write(16 + i, i + 1);
        end
        d0 = done_pulses;
        issue_cmd(2'b00, 2'd0);
        check_eq("busy_after_cmd", busy, 1);
        wait_done();
        check_eq("busy_at_done", busy, 0);
        tick();
        check_eq("done_once", done_pulses - d0, 1);
        check_eq("done_pulse_width", command_done, 0);
        for (int i = 0; i < 16; i++) begin
            host_read(32 + i, d);
            check_eq($sformatf("matmul_r%0d", i), d, i + 1);
        end
        host_read(0, d);
        check_eq("matmul_m1_kept", d, 1);

        // simultaneous write and command: write wins
        host_write_address  = 6'd20;
        host_write_data     = 8'sd50;
        host_write_valid    = 1'b1;
        command_operation   = 2'b01;
        command_destination = 2'd0;
        command_valid       = 1'b1;
        #1;
        check_eq("simul_cmd_ready", command_ready, 0);
        check_eq("simul_write_ready", host_write_ready, 1);
        @(posedge clock_in);
        #1;
        host_write_valid = 1'b0;
        #1;
        check_eq("simul_busy_held", busy, 0);
        check_eq("simul_cmd_ready_next", command_ready, 1);
        tick();
        command_valid = 1'b0;
        check_eq("simul_cmd_taken", busy, 1);
        wait_done();
        host_read(36, d);
        check_eq("add_r36", d, 50);
        host_read(32, d);
        check_eq("add_r32", d, 2);
        host_read(37, d);
        check_eq("add_r37", d, 7);

        // add with write-back to matrix1, then relu chain
        for (int i = 0; i < 16; i++) begin
            host_write(i, -3);
            host_write(16 + i, 5);
        end
        issue_cmd(2'b01, 2'd1);
        wait_done();
        check_eq("wb_in1_at_done", tc_in1[0][0], 2);
        check_eq("wb_in1_3_3", tc_in1[3][3], 2);
        host_read(32, d);
        check_eq("wb_r32", d, 2);
        host_read(47, d);
        check_eq("wb_r47", d, 2);
        host_read(15, d);
        check_eq("wb_m1_15", d, 2);
        issue_cmd(2'b10, 2'd0);
        wait_done();
        host_read(40, d);
        check_eq("relu_pos", d, 2);
        for (int i = 0; i < 16; i++) host_write(i, -1);
        issue_cmd(2'b11, 2'd3);
        wait_done();
        host_read(33, d);
        check_eq("relu_neg", d, 0);
        host_read(0, d);
        check_eq("dest3_m1_kept", d, -1);

        // write attempt while waiting on the core
        core_lat = 20;
        issue_cmd(2'b10, 2'd0);
        repeat (10) tick();
        check_eq("wait_busy", busy, 1);
        w0 = we_pulses;
        host_write_address = 6'd0;
        host_write_data    = 8'sd99;
        host_write_valid   = 1'b1;
        #1;
        check_eq("wait_write_ready", host_write_ready, 0);
        repeat (3) tick();
        host_write_valid = 1'b0;
        wait_done();
        tick();
        check_eq("wait_no_we", we_pulses - w0, 0);
        host_read(0, d);
        check_eq("wait_m1_kept", d, -1);

        // reset while waiting, then a command that must absorb the in-flight calculation
        core_lat = 30;
        issue_cmd(2'b00, 2'd0);
        repeat (10) tick();
        check_eq("pre_reset_busy", busy, 1);
        d0 = done_pulses;
        reset_n_in = 1'b0;
        #1;
        check_eq("reset_busy_drop", busy, 0);
        check_eq("reset_write_ready", host_write_ready, 0);
        repeat (2) tick();
        reset_n_in = 1'b1;
        core_lat = 3;
        repeat (3) tick();
        check_eq("reset_no_done", done_pulses - d0, 0);
        host_read(32, d);
        check_eq("reset_result_clear", d, 0);
        host_write(0, 4);
        host_write(16, 5);
        issue_cmd(2'b01, 2'd0);
        wait_done();
        host_read(32, d);
        check_eq("post_reset_r32", d, 9);
        host_read(33, d);
        check_eq("post_reset_r33", d, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tensor_core_register_file.md
# tensor_core_register_file

Operand/result register file sitting directly upstream of `small_tensor_core`: holds the two 4×4 signed int8 operand matrices and a 4×4 result matrix, and gives the host a byte-wide write/read port plus a command handshake. A command sequences the core through start, calculation and completion. It then captures the core's output into the result matrix, and optionally back into an operand matrix so operations can be chained (matmul → relu, for example).

## Interface
- `ADDR_WIDTH`, 6: host byte address width.
- `clock_in` in 1: single clock; all state updates on the rising edge.
- `reset_n_in` in 1: reset, asynchronous, active-low.
- `host_write_valid` in 1: write request.
- `host_write_ready` out 1: write accepted when valid && ready.
- `host_write_address` in 6: 0–15 matrix1, 16–31 matrix2, row-major (`addr[3:0] = row*4+col`).
- `host_write_data` in 8: signed element.
- `host_read_address` in 6: 0–15 matrix1, 16–31 matrix2, 32–47 result, 48–63 read 0.
- `host_read_data` out 8: registered; one-cycle latency.
- `command_valid` in 1: command request.
- `command_ready` out 1: command accepted when valid && ready.
- `command_operation` in 2: 00 matmul, 01 add, 1x relu.
- `command_destination` in 2: 0 result only, 1 also matrix1, 2 also matrix2, 3 result only.
- `command_done` out 1: one-cycle pulse when the result has been captured.
- `busy` out 1: high whenever state ≠ IDLE.
- `tensor_core_input1`, `tensor_core_input2` out signed 8 [4][4]: direct views of matrix1 and matrix2.
- `tensor_core_register_file_write_enable` out 1: one-cycle pulse after each accepted operand write.
- `should_start_tensor_core` out 1: start pulse.
- `operation_select` out 2: latched command operation.
- `tensor_core_output` in signed 8 [4][4]: core result.
- `is_done_with_calculation` in 1: core completion level.

## Operation
- States:
  - IDLE: `host_write_ready` = 1. `command_ready` = !`host_write_valid`, so a write wins over a simultaneous command.
  - Accepted write to 0–31: updates the element and pulses `tensor_core_register_file_write_enable` on the next cycle. Writes to 32–63 are accepted and dropped, with no pulse.
  - Accepted command: latch operation and destination, then go to ARM.
  - ARM: wait for `is_done_with_calculation` = 1 (the core may still be recomputing after a write pulse), then go to START.
  - START: `should_start_tensor_core` = 1 for exactly one cycle, then go to ACK.
  - ACK: wait for `is_done_with_calculation` = 0, then go to WAIT.
  - WAIT: wait for `is_done_with_calculation` = 1, then go to CAPTURE.
  - CAPTURE: copy all 16 output elements into the result matrix; if destination is 1 or 2, also overwrite that operand matrix. Pulse `command_done`, then return to IDLE.
- All data is signed 8-bit. No widening or saturation; the core already truncates.
- No host writes are accepted while busy, so operands are stable throughout a calculation.

## Timing
- Reset values: all matrices 0; `host_write_ready` 0 during reset, 1 after; `command_ready` 0 during reset; `host_read_data` 0; all pulses 0; `operation_select` 0; state IDLE.
- Host read: data for the address sampled at edge N appears after edge N. Reads are allowed in any state. A result read in the cycle after CAPTURE returns the new value.
- Command latency with the core idle: accept at edge 0; ARM at 1; START pulse at 1–2; ACK; WAIT; CAPTURE; `command_done` high for one cycle. Both ACK and WAIT must tolerate arbitrarily long waits.
- Reset mid-command: state returns to IDLE at once and no `command_done` is issued. The core is not reset; the next command's ARM absorbs any in-flight calculation.
- CAPTURE with destination 1: matrix1 and `tensor_core_input1` change on the same edge as `command_done`.

## Structure
- Package `tensor_core_pkg`:
  - `BUS_WIDTH` and matrix dimension constants.
  - `tensor_op_e` (MATMUL, ADD, RELU).
  - `tensor_dest_e`.
  - `regfile_state_e`.
  - Address-region constants.
- Single module, no sub-modules; the 3×16 byte arrays are flop arrays.

## Test plan
- Write matrix1 = identity and matrix2 = elements 1..16, then issue matmul with destination 0 → `command_done` pulses once; reading 32–47 returns 1..16.
- Write a single element (address 5 = 7) → exactly one `tensor_core_register_file_write_enable` pulse; a read at address 5 returns 7 after one cycle.
- Matrix1 all −3 and matrix2 all 5, add with destination 1 → matrix1 and result both all 2; a following relu command leaves 2. With matrix1 = −1, relu gives 0.
- `host_write_valid` and `command_valid` asserted in the same cycle → the write is accepted and the command is held off until the next cycle.
- Write during WAIT → `host_write_ready` = 0 and the matrix is unchanged.
- Assert `reset_n_in` low during WAIT → `busy` drops immediately with no done pulse. A following command completes correctly even if the core was still calculating.
